// File: rtl/crossbar_slave_responder_pkg.sv
// Shared definitions for the crossbar slave responder: command encoding,
// FSM state type, error read pattern and bus width constants.
package crossbar_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/crossbar_slave_responder_mem.sv
// Word array for the responder: one write port, one registered read port,
// synchronous clear of every word and of the read register.
module responder_mem
    import crossbar_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
)(
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/crossbar_slave_responder.sv
// Crossbar slave responder: IDLE/WAIT/ACK handshake over a small word array.
// Define CROSSBAR_SLAVE_STATS_EN to add saturating rd_cnt/wr_cnt outputs.
module crossbar_slave_responder
    import crossbar_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 4,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
`ifdef CROSSBAR_SLAVE_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt;
    logic [29:0]       r_addr;
    logic              r_cmd;
    logic [DATA_W-1:0] r_wdata;
    logic              r_oor_rd;

    logic [29:0]       w_addr;
    logic              w_cmd;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range, w_enter_ack, w_we, w_re;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_unused_byte_lanes;

    assign w_unused_byte_lanes = ^addr[1:0];

    // With WAIT_CYCLES=0 the array is accessed on the accepting edge itself,
    // so the live inputs stand in for the not-yet-captured registers.
    assign w_addr  = (r_state == IDLE) ? addr[31:2] : r_addr;
    assign w_cmd   = (r_state == IDLE) ? cmd        : r_cmd;
    assign w_wdata = (r_state == IDLE) ? wdata      : r_wdata;

    assign w_in_range  = (w_addr[29:DEPTH_LOG2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign w_enter_ack = (r_state != ACK) && (w_state_next == ACK);
    assign w_we        = w_enter_ack && (w_cmd == CMD_WRITE) && w_in_range;
    assign w_re        = w_enter_ack && (w_cmd == CMD_READ) && w_in_range;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (req) w_state_next = (WAIT_CYCLES > 0) ? WAIT : ACK;
            WAIT: if (r_cnt == '0) w_state_next = ACK;
            ACK:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_cmd    <= CMD_READ;
            r_wdata  <= '0;
            r_oor_rd <= 1'b0;
        end else begin
            if (r_state == IDLE && req) begin
                r_addr  <= addr[31:2];
                r_cmd   <= cmd;
                r_wdata <= wdata;
                r_cnt   <= WAIT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Out-of-range flag only changes on reads so rdata holds across writes.
            if (w_enter_ack && w_cmd == CMD_READ) begin
                r_oor_rd <= !w_in_range;
            end
        end
    end

    responder_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .i_clr   (reset),
        .i_we    (w_we),
        .i_waddr (w_addr[DEPTH_LOG2-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_addr[DEPTH_LOG2-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign ack   = (r_state == ACK);
    assign rdata = r_oor_rd ? ERR_RDATA : w_mem_rdata;

`ifdef CROSSBAR_SLAVE_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (r_state == ACK) begin
            if (r_cmd == CMD_READ && r_rd_cnt != '1)  r_rd_cnt <= r_rd_cnt + 16'd1;
            if (r_cmd == CMD_WRITE && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_crossbar_slave_responder.sv
// Directed self-checking bench: default-parameter responder plus a
// WAIT_CYCLES=0 instance for back-to-back handshakes.
module tb_crossbar_slave_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req, cmd, ack;
    logic [31:0] addr, wdata, rdata;
    logic        reset0, req0, cmd0, ack0;
    logic [31:0] addr0, wdata0, rdata0;
`ifdef CROSSBAR_SLAVE_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

    int passed = 0;
    int total  = 0;

    crossbar_slave_responder dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .cmd(cmd),
        .wdata(wdata), .ack(ack), .rdata(rdata)
`ifdef CROSSBAR_SLAVE_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
    );

    crossbar_slave_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset0), .req(req0), .addr(addr0), .cmd(cmd0),
        .wdata(wdata0), .ack(ack0), .rdata(rdata0)
`ifdef CROSSBAR_SLAVE_STATS_EN
        , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on dut; lat = edges from the accepting edge until ack seen.
    task automatic do_txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic ack_after);
        req = 1'b1; cmd = c; addr = a; wdata = d;
        tick();
        req = 1'b0; cmd = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'h5555_AAAA;
        lat = 1;
        while (ack !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (ack !== 1'b1) lat = 99;
        rd = rdata;
        tick();
        ack_after = ack;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset0 = 1'b1;
        req = 0; cmd = 0; addr = '0; wdata = '0;
        req0 = 0; cmd0 = 0; addr0 = '0; wdata0 = '0;
        tick(); tick();
        total++; if (ack !== 1'b0)       $display("FAIL reset_ack got %b want 0", ack); else passed++;
        total++; if (rdata !== 32'h0)    $display("FAIL reset_rdata got %h want 0", rdata); else passed++;
        total++; if (ack0 !== 1'b0)      $display("FAIL reset_ack0 got %b want 0", ack0); else passed++;
        total++; if (rdata0 !== 32'h0)   $display("FAIL reset_rdata0 got %h want 0", rdata0); else passed++;
        reset = 1'b0; reset0 = 1'b0;
        tick();
        total++; if (ack !== 1'b0)       $display("FAIL idle_ack got %b want 0", ack); else passed++;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic aa;
        do_txn(1'b1, 32'h8, 32'hA5A5_0001, lat, rd, aa);
        total++; if (lat !== 3)     $display("FAIL wr_latency got %0d want 3", lat); else passed++;
        total++; if (aa !== 1'b0)   $display("FAIL wr_ack_width got %b want 0", aa); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL wr_rdata_keep got %h want 0", rdata); else passed++;
        do_txn(1'b0, 32'h8, 32'h0, lat, rd, aa);
        total++; if (lat !== 3)     $display("FAIL rd_latency got %0d want 3", lat); else passed++;
        total++; if (rd !== 32'hA5A5_0001) $display("FAIL rd_data got %h want a5a50001", rd); else passed++;
        total++; if (aa !== 1'b0)   $display("FAIL rd_ack_width got %b want 0", aa); else passed++;
        do_txn(1'b0, 32'hB, 32'h0, lat, rd, aa);
        total++; if (rd !== 32'hA5A5_0001) $display("FAIL rd_byte_lanes got %h want a5a50001", rd); else passed++;
    endtask

    task automatic test_rdata_hold();
        int lat; logic [31:0] rd; logic aa;
        do_txn(1'b1, 32'h0, 32'h1111_2222, lat, rd, aa);
        total++; if (rdata !== 32'hA5A5_0001) $display("FAIL rdata_hold got %h want a5a50001", rdata); else passed++;
        repeat (3) tick();
        total++; if (rdata !== 32'hA5A5_0001) $display("FAIL rdata_hold_idle got %h want a5a50001", rdata); else passed++;
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic aa;
        do_txn(1'b0, 32'h0000_0100, 32'h0, lat, rd, aa);
        total++; if (lat !== 3)            $display("FAIL oor_rd_latency got %0d want 3", lat); else passed++;
        total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL oor_rd_data got %h want deadbeef", rd); else passed++;
        do_txn(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, lat, rd, aa);
        total++; if (lat !== 3)            $display("FAIL oor_wr_latency got %0d want 3", lat); else passed++;
        total++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL oor_wr_rdata_keep got %h want deadbeef", rdata); else passed++;
        do_txn(1'b0, 32'h0, 32'h0, lat, rd, aa);
        total++; if (rd !== 32'h1111_2222) $display("FAIL oor_wr_dropped w0 got %h want 11112222", rd); else passed++;
        do_txn(1'b0, 32'h8, 32'h0, lat, rd, aa);
        total++; if (rd !== 32'hA5A5_0001) $display("FAIL oor_wr_dropped w2 got %h want a5a50001", rd); else passed++;
    endtask

    task automatic test_capture();
        int lat; logic [31:0] rd; logic aa;
        req = 1'b1; cmd = 1'b1; addr = 32'hC; wdata = 32'hC0FF_EE00;
        tick();
        req = 1'b0; cmd = 1'b0; addr = 32'h4; wdata = 32'h0000_0BAD;
        lat = 1;
        while (ack !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++; if (lat !== 3) $display("FAIL req_drop_latency got %0d want 3", lat); else passed++;
        tick();
        do_txn(1'b0, 32'hC, 32'h0, lat, rd, aa);
        total++; if (rd !== 32'hC0FF_EE00) $display("FAIL capture_data got %h want c0ffee00", rd); else passed++;
        do_txn(1'b0, 32'h4, 32'h0, lat, rd, aa);
        total++; if (rd !== 32'h0) $display("FAIL capture_addr w1 got %h want 0", rd); else passed++;
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd; logic aa;
        req = 1'b1; cmd = 1'b1; addr = 32'h4; wdata = 32'h1234;
        tick();
        req = 1'b0;
        reset = 1'b1;
        tick();
        total++; if (ack !== 1'b0)    $display("FAIL abort_ack got %b want 0", ack); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL abort_rdata got %h want 0", rdata); else passed++;
        reset = 1'b0;
        do_txn(1'b0, 32'h4, 32'h0, lat, rd, aa);
        total++; if (lat !== 3)       $display("FAIL post_reset_latency got %0d want 3", lat); else passed++;
        total++; if (rd !== 32'h0)    $display("FAIL abort_no_commit got %h want 0", rd); else passed++;
        do_txn(1'b0, 32'hC, 32'h0, lat, rd, aa);
        total++; if (rd !== 32'h0)    $display("FAIL reset_clears_array got %h want 0", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        logic [31:0] last_rd;
        req0 = 1'b1; cmd0 = 1'b0; addr0 = 32'h0;
        last_rd = 32'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen[i] = ack0;
            if (ack0 === 1'b1) begin
                if (rdata0 !== 32'h0) last_rd = rdata0;
                addr0 = addr0 + 32'h4;
            end
            if (i == 4) req0 = 1'b0;
        end
        total++; if (seen !== 6'b01_0101) $display("FAIL b2b_ack_pattern got %b want 010101", seen); else passed++;
        total++; if (last_rd !== 32'h0)   $display("FAIL b2b_rdata got %h want 0", last_rd); else passed++;
        req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h0BAD_F00D;
        tick();
        total++; if (ack0 !== 1'b1) $display("FAIL wc0_wr_ack got %b want 1", ack0); else passed++;
        cmd0 = 1'b0;
        tick(); tick();
        total++; if (rdata0 !== 32'h0BAD_F00D) $display("FAIL wc0_rd_data got %h want 0badf00d", rdata0); else passed++;
        req0 = 1'b0;
        tick();
    endtask

`ifdef CROSSBAR_SLAVE_STATS_EN
    task automatic test_stats();
        int lat; logic [31:0] rd; logic aa;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (rd_cnt !== 16'h0) $display("FAIL stats_reset got %h want 0", rd_cnt); else passed++;
        for (int i = 0; i < 5; i++) do_txn(1'b0, 32'(i * 4), 32'h0, lat, rd, aa);
        do_txn(1'b1, 32'h0, 32'h1, lat, rd, aa);
        do_txn(1'b1, 32'h4, 32'h2, lat, rd, aa);
        do_txn(1'b1, 32'h200, 32'h3, lat, rd, aa);
        total++; if (rd_cnt !== 16'd5) $display("FAIL stats_rd_cnt got %0d want 5", rd_cnt); else passed++;
        total++; if (wr_cnt !== 16'd3) $display("FAIL stats_wr_cnt got %0d want 3", wr_cnt); else passed++;
        force dut.r_rd_cnt = 16'hFFFF;
        #1;
        release dut.r_rd_cnt;
        do_txn(1'b0, 32'h0, 32'h0, lat, rd, aa);
        total++; if (rd_cnt !== 16'hFFFF) $display("FAIL stats_saturate got %h want ffff", rd_cnt); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_rdata_hold();
        test_out_of_range();
        test_capture();
        test_abort();
        test_back_to_back();
`ifdef CROSSBAR_SLAVE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/crossbar_slave_responder.md
CROSSBAR_SLAVE_RESPONDER -- requirements
Module: crossbar_slave_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving a word array of 2**DEPTH_LOG2 x 32 bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, giving wait states before ack.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the region base, aligned to 4*2**DEPTH_LOG2.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk is the only clock and reset is the only reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req  input  1  request from the crossbar slave port (rreq[i]).
REQ-008 addr  input  32  byte address (aaddr slice).
REQ-009 cmd  input  1  0=read, 1=write (ccmd[i]).
REQ-010 wdata  input  32  write data (wwdata slice).
REQ-011 ack  output  1  one-cycle completion pulse (aack[i]).
REQ-012 rdata  output  32  read data (rrdata slice).

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and ACK.
REQ-014 IDLE with req=1 SHALL capture addr, cmd and wdata, then go to WAIT if WAIT_CYCLES>0, else go to ACK; later input changes SHALL be ignored until ACK.
REQ-015 WAIT SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry, decrement it every cycle, and go to ACK when it reads 0.
REQ-016 ack SHALL be 1 only in ACK, for exactly one cycle; ACK SHALL always return to IDLE.
REQ-017 Latency: req sampled at edge N gives ack=1 in the cycle after edge N+1+WAIT_CYCLES.
REQ-018 req still 1 in the cycle after ack SHALL be accepted as a new transaction, with no bubble beyond that IDLE cycle.
REQ-019 Decode: in range when addr[31:DEPTH_LOG2+2] equals BASE_ADDR[31:DEPTH_LOG2+2]; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] SHALL be ignored.
REQ-020 In-range write SHALL update the word on the edge entering ACK; rdata SHALL keep its previous value.
REQ-021 In-range read SHALL register the word onto rdata on the edge entering ACK, valid while ack=1.
REQ-022 Out-of-range write SHALL be dropped and still acked; out-of-range read SHALL return 32'hDEAD_BEEF and still ack.
REQ-023 rdata SHALL hold its last value between reads.
REQ-024 req dropping during WAIT SHALL NOT abort the transaction; ack SHALL still be issued.

Reset
REQ-025 While reset=1 at an edge: state goes to IDLE, ack=0, rdata=0, counter=0, and every array word=0.
REQ-026 Reset asserted mid-transaction (WAIT or ACK) SHALL abandon it: no write commits and no ack pulse follows.
REQ-027 req=1 on the first edge after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro CROSSBAR_SLAVE_STATS_EN, when defined, SHALL add outputs rd_cnt[15:0] and wr_cnt[15:0], each incremented on the ack cycle of a read or write and saturating at 16'hFFFF.
REQ-029 The counters SHALL count out-of-range accesses and SHALL reset to 0.
REQ-030 Without the macro, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package crossbar_pkg SHALL hold CMD_READ/CMD_WRITE, the FSM state enum, ERR_RDATA=32'hDEAD_BEEF and the 32-bit data/address width constants.
REQ-032 The word array SHALL be one sub-module, responder_mem: one write port and one registered read port with synchronous clear; FSM, counter and decode SHALL stay in the top.

Verification
REQ-033 Default params, write 32'hA5A5_0001 to addr 0x8, then read 0x8 -> ack 3 cycles after each accepted req; read rdata=32'hA5A5_0001.
REQ-034 WAIT_CYCLES=0, req held high across 3 back-to-back reads of 0x0, 0x4, 0x8 -> ack on every second cycle, rdata 0 each time after reset.
REQ-035 Read 0x0000_0100 (out of range, DEPTH_LOG2=4) -> ack, rdata=32'hDEAD_BEEF; a write to 0x100 leaves all words unchanged.
REQ-036 Write 0x1234 to 0x4, assert reset one cycle into WAIT -> no ack; read of 0x4 after reset returns 0.
REQ-037 Change addr/wdata during WAIT of a write to 0xC -> the originally captured values are written.
REQ-038 With CROSSBAR_SLAVE_STATS_EN, 5 reads and 3 writes (one out of range) -> rd_cnt=5, wr_cnt=3; forcing rd_cnt to 16'hFFFF then one more read -> it stays 16'hFFFF.
